// File: rtl/rif_arb_pkg.sv
// Shared types for the rif arbiter: FSM states, transfer kinds and index sizing.
package rif_arb_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        ACK   = 2'd2
    } state_e;

    typedef enum logic {
        XFER_RD = 1'b0,
        XFER_WR = 1'b1
    } xfer_e;

    localparam int unsigned NUM_REQ_MAX = 8;

    function automatic int unsigned idx_width(input int unsigned n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/rif_rr_picker.sv
// Combinational round-robin picker: first pending requester at or after ptr, wrapping.
module rif_rr_picker
    import rif_arb_pkg::*;
#(
    parameter int unsigned NUM_REQ = 2,
    parameter int unsigned IDX_W   = idx_width(NUM_REQ)
) (
    input  logic [NUM_REQ-1:0] pending_i,
    input  logic [IDX_W-1:0]   ptr_i,
    output logic [IDX_W-1:0]   winner_o,
    output logic               any_o
);

    logic [IDX_W-1:0] cand;

    always_comb begin
        winner_o = '0;
        any_o    = 1'b0;
        cand     = '0;
        for (int k = 0; k < int'(NUM_REQ); k++) begin
            cand = IDX_W'((int'(ptr_i) + k) % int'(NUM_REQ));
            if (!any_o && pending_i[cand]) begin
                any_o    = 1'b1;
                winner_o = cand;
            end
        end
    end

endmodule

// File: rtl/rif_arbiter.sv
// Round-robin arbiter sharing one rif target between NUM_REQ requesters, one access in flight.
// Optional requester lock is enabled by defining RIF_ARB_LOCK_EN.
module rif_arbiter
    import rif_arb_pkg::*;
#(
    parameter int unsigned NUM_REQ    = 2,
    parameter int unsigned ADDR_WIDTH = 12,
    parameter int unsigned DATA_WIDTH = 32,
    parameter int unsigned BYTE_COUNT = (DATA_WIDTH < 8) ? 1 : 2 ** ($clog2(DATA_WIDTH) - 3)
) (
    input  logic                             pclk,
    input  logic                             presetn,
    input  logic [NUM_REQ-1:0]               m_wr_req,
    input  logic [NUM_REQ-1:0]               m_rd_req,
    input  logic [NUM_REQ*ADDR_WIDTH-1:0]    m_addr,
    input  logic [NUM_REQ*BYTE_COUNT-1:0]    m_wstrb,
    input  logic [NUM_REQ*DATA_WIDTH-1:0]    m_wdata,
`ifdef RIF_ARB_LOCK_EN
    input  logic [NUM_REQ-1:0]               m_lock,
`endif
    output logic [NUM_REQ-1:0]               m_ack,
    output logic                             m_err,
    output logic [DATA_WIDTH-1:0]            m_rdata,
    output logic [ADDR_WIDTH-1:0]            rif_addr,
    output logic                             rif_wr_req,
    output logic                             rif_rd_req,
    output logic [BYTE_COUNT-1:0]            rif_wstrb,
    output logic [DATA_WIDTH-1:0]            rif_wdata,
    input  logic                             rif_wvalid,
    input  logic                             rif_rvalid,
    input  logic [DATA_WIDTH-1:0]            rif_rdata
);

    localparam int unsigned IDX_W = idx_width(NUM_REQ);

    logic [ADDR_WIDTH-1:0] addr_arr  [NUM_REQ];
    logic [BYTE_COUNT-1:0] wstrb_arr [NUM_REQ];
    logic [DATA_WIDTH-1:0] wdata_arr [NUM_REQ];

    for (genvar g = 0; g < NUM_REQ; g++) begin : g_unpack
        assign addr_arr[g]  = m_addr[g*ADDR_WIDTH +: ADDR_WIDTH];
        assign wstrb_arr[g] = m_wstrb[g*BYTE_COUNT +: BYTE_COUNT];
        assign wdata_arr[g] = m_wdata[g*DATA_WIDTH +: DATA_WIDTH];
    end

    state_e                state_q, state_d;
    xfer_e                 xfer_q, xfer_d;
    logic [IDX_W-1:0]      ptr_q, ptr_d;
    logic [IDX_W-1:0]      winner_q, winner_d;
    logic [ADDR_WIDTH-1:0] addr_q, addr_d;
    logic [BYTE_COUNT-1:0] wstrb_q, wstrb_d;
    logic [DATA_WIDTH-1:0] wdata_q, wdata_d;
    logic                  wr_req_q, wr_req_d;
    logic                  rd_req_q, rd_req_d;
    logic [NUM_REQ-1:0]    ack_q, ack_d;
    logic                  err_q, err_d;
    logic [DATA_WIDTH-1:0] rdata_q, rdata_d;

    logic [NUM_REQ-1:0] pending;
    logic [NUM_REQ-1:0] pick_pending;
    logic [IDX_W-1:0]   pick_idx;
    logic               pick_any;
    logic [IDX_W-1:0]   next_ptr;

    assign pending  = m_wr_req | m_rd_req;
    assign next_ptr = (winner_q == IDX_W'(NUM_REQ - 1)) ? '0 : winner_q + 1'b1;

`ifdef RIF_ARB_LOCK_EN
    logic             lock_q, lock_d;
    logic [IDX_W-1:0] lock_idx_q, lock_idx_d;
    logic             lock_hold;

    // A lock only masks others while its owner still has a request outstanding.
    assign lock_hold = lock_q & pending[lock_idx_q];

    always_comb begin
        pick_pending = pending;
        if (lock_hold) begin
            pick_pending             = '0;
            pick_pending[lock_idx_q] = 1'b1;
        end
    end
`else
    assign pick_pending = pending;
`endif

    rif_rr_picker #(
        .NUM_REQ (NUM_REQ),
        .IDX_W   (IDX_W)
    ) u_picker (
        .pending_i (pick_pending),
        .ptr_i     (ptr_q),
        .winner_o  (pick_idx),
        .any_o     (pick_any)
    );

    always_comb begin
        state_d  = state_q;
        xfer_d   = xfer_q;
        ptr_d    = ptr_q;
        winner_d = winner_q;
        addr_d   = addr_q;
        wstrb_d  = wstrb_q;
        wdata_d  = wdata_q;
        err_d    = err_q;
        rdata_d  = rdata_q;
        wr_req_d = 1'b0;
        rd_req_d = 1'b0;
        ack_d    = '0;
`ifdef RIF_ARB_LOCK_EN
        lock_d     = lock_q;
        lock_idx_d = lock_idx_q;
`endif
        unique case (state_q)
            IDLE: begin
`ifdef RIF_ARB_LOCK_EN
                if (lock_q && !lock_hold) begin
                    lock_d = 1'b0;
                end
`endif
                if (pick_any) begin
                    winner_d = pick_idx;
                    // Write wins when a requester raises both; its read stays pending.
                    xfer_d   = m_wr_req[pick_idx] ? XFER_WR : XFER_RD;
                    addr_d   = addr_arr[pick_idx];
                    wstrb_d  = wstrb_arr[pick_idx];
                    wdata_d  = wdata_arr[pick_idx];
                    wr_req_d = m_wr_req[pick_idx];
                    rd_req_d = ~m_wr_req[pick_idx];
                    state_d  = ISSUE;
                end
            end
            ISSUE: begin
                if (xfer_q == XFER_WR) begin
                    err_d = ~rif_wvalid;
                end else begin
                    err_d   = ~rif_rvalid;
                    rdata_d = rif_rdata;
                end
                ack_d[winner_q] = 1'b1;
                state_d         = ACK;
            end
            ACK: begin
`ifdef RIF_ARB_LOCK_EN
                if (m_lock[winner_q]) begin
                    lock_d     = 1'b1;
                    lock_idx_d = winner_q;
                end else begin
                    lock_d = 1'b0;
                    ptr_d  = next_ptr;
                end
`else
                ptr_d = next_ptr;
`endif
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge pclk) begin
        if (!presetn) begin
            state_q  <= IDLE;
            xfer_q   <= XFER_RD;
            ptr_q    <= '0;
            winner_q <= '0;
            addr_q   <= '0;
            wstrb_q  <= '0;
            wdata_q  <= '0;
            wr_req_q <= 1'b0;
            rd_req_q <= 1'b0;
            ack_q    <= '0;
            err_q    <= 1'b0;
            rdata_q  <= '0;
        end else begin
            state_q  <= state_d;
            xfer_q   <= xfer_d;
            ptr_q    <= ptr_d;
            winner_q <= winner_d;
            addr_q   <= addr_d;
            wstrb_q  <= wstrb_d;
            wdata_q  <= wdata_d;
            wr_req_q <= wr_req_d;
            rd_req_q <= rd_req_d;
            ack_q    <= ack_d;
            err_q    <= err_d;
            rdata_q  <= rdata_d;
        end
    end

`ifdef RIF_ARB_LOCK_EN
    always_ff @(posedge pclk) begin
        if (!presetn) begin
            lock_q     <= 1'b0;
            lock_idx_q <= '0;
        end else begin
            lock_q     <= lock_d;
            lock_idx_q <= lock_idx_d;
        end
    end
`endif

    assign m_ack      = ack_q;
    assign m_err      = err_q;
    assign m_rdata    = rdata_q;
    assign rif_addr   = addr_q;
    assign rif_wr_req = wr_req_q;
    assign rif_rd_req = rd_req_q;
    assign rif_wstrb  = wstrb_q;
    assign rif_wdata  = wdata_q;

endmodule

// File: tb/tb_rif_arbiter.sv
// Scoreboard bench for rif_arbiter: directed transfers push expected rif strobes and acks,
// a negedge monitor pops and compares them.
module tb_rif_arbiter;

    localparam int NR = 2;
    localparam int AW = 12;
    localparam int DW = 32;
    localparam int BC = 4;

    logic              pclk;
    logic              presetn;
    logic [NR-1:0]     m_wr_req;
    logic [NR-1:0]     m_rd_req;
    logic [NR*AW-1:0]  m_addr;
    logic [NR*BC-1:0]  m_wstrb;
    logic [NR*DW-1:0]  m_wdata;
`ifdef RIF_ARB_LOCK_EN
    logic [NR-1:0]     m_lock;
`endif
    logic [NR-1:0]     m_ack;
    logic              m_err;
    logic [DW-1:0]     m_rdata;
    logic [AW-1:0]     rif_addr;
    logic              rif_wr_req;
    logic              rif_rd_req;
    logic [BC-1:0]     rif_wstrb;
    logic [DW-1:0]     rif_wdata;
    logic              rif_wvalid;
    logic              rif_rvalid;
    logic [DW-1:0]     rif_rdata;

    rif_arbiter #(
        .NUM_REQ    (NR),
        .ADDR_WIDTH (AW),
        .DATA_WIDTH (DW)
    ) dut (
        .pclk       (pclk),
        .presetn    (presetn),
        .m_wr_req   (m_wr_req),
        .m_rd_req   (m_rd_req),
        .m_addr     (m_addr),
        .m_wstrb    (m_wstrb),
        .m_wdata    (m_wdata),
`ifdef RIF_ARB_LOCK_EN
        .m_lock     (m_lock),
`endif
        .m_ack      (m_ack),
        .m_err      (m_err),
        .m_rdata    (m_rdata),
        .rif_addr   (rif_addr),
        .rif_wr_req (rif_wr_req),
        .rif_rd_req (rif_rd_req),
        .rif_wstrb  (rif_wstrb),
        .rif_wdata  (rif_wdata),
        .rif_wvalid (rif_wvalid),
        .rif_rvalid (rif_rvalid),
        .rif_rdata  (rif_rdata)
    );

    typedef struct {
        logic [NR-1:0] ack;
        logic          err;
        logic [DW-1:0] rdata;
        int            cyc;
    } ack_exp_t;

    typedef struct {
        logic          wr;
        logic [AW-1:0] addr;
        logic [DW-1:0] wdata;
        logic [BC-1:0] wstrb;
        int            cyc;
    } rif_exp_t;

    ack_exp_t ack_q[$];
    rif_exp_t rif_q[$];
    int n_cmp = 0;
    int n_err = 0;
    int cyc = 0;

    initial pclk = 1'b0;
    always #5 pclk = ~pclk;
    always @(posedge pclk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Monitor: every ack and every rif strobe must match the head of its queue.
    always @(negedge pclk) begin
        if (m_ack != '0) begin
            if (ack_q.size() == 0) begin
                chk("unexpected_ack", 64'(m_ack), 64'(0));
            end else begin
                ack_exp_t e;
                e = ack_q.pop_front();
                chk("ack_onehot", 64'(m_ack), 64'(e.ack));
                chk("ack_err", 64'(m_err), 64'(e.err));
                chk("ack_rdata", 64'(m_rdata), 64'(e.rdata));
                chk("ack_cycle", 64'(cyc), 64'(e.cyc));
            end
        end
        if (rif_wr_req || rif_rd_req) begin
            chk("rif_strobe_excl", 64'(rif_wr_req & rif_rd_req), 64'(0));
            if (rif_q.size() == 0) begin
                chk("unexpected_rif", 64'(rif_addr), 64'(0));
            end else begin
                rif_exp_t r;
                r = rif_q.pop_front();
                chk("rif_wr_req", 64'(rif_wr_req), 64'(r.wr));
                chk("rif_addr", 64'(rif_addr), 64'(r.addr));
                chk("rif_cycle", 64'(cyc), 64'(r.cyc));
                if (r.wr) begin
                    chk("rif_wdata", 64'(rif_wdata), 64'(r.wdata));
                    chk("rif_wstrb", 64'(rif_wstrb), 64'(r.wstrb));
                end
            end
        end
    end

    task automatic step(input int n);
        repeat (n) @(posedge pclk);
        #1;
    endtask

    task automatic set_req(input int i, input logic wr, input logic [AW-1:0] addr,
                           input logic [DW-1:0] wdata, input logic [BC-1:0] wstrb);
        m_wr_req[i]           = wr;
        m_rd_req[i]           = !wr;
        m_addr[i*AW +: AW]    = addr;
        m_wdata[i*DW +: DW]   = wdata;
        m_wstrb[i*BC +: BC]   = wstrb;
    endtask

    task automatic drop(input int i);
        m_wr_req[i] = 1'b0;
        m_rd_req[i] = 1'b0;
    endtask

    task automatic exp_ack(input logic [NR-1:0] ack, input logic err, input logic [DW-1:0] rdata,
                           input int c);
        ack_exp_t e;
        e.ack = ack; e.err = err; e.rdata = rdata; e.cyc = c;
        ack_q.push_back(e);
    endtask

    task automatic exp_rif(input logic wr, input logic [AW-1:0] addr, input logic [DW-1:0] wdata,
                           input logic [BC-1:0] wstrb, input int c);
        rif_exp_t r;
        r.wr = wr; r.addr = addr; r.wdata = wdata; r.wstrb = wstrb; r.cyc = c;
        rif_q.push_back(r);
    endtask

    // One lone transfer: strobe one cycle after the IDLE that sees it, ack one cycle later.
    task automatic single(input int i, input logic wr, input logic [AW-1:0] addr,
                          input logic [DW-1:0] wdata, input logic [BC-1:0] wstrb,
                          input logic [NR-1:0] ack, input logic err, input logic [DW-1:0] rdata);
        int k;
        k = cyc;
        set_req(i, wr, addr, wdata, wstrb);
        exp_rif(wr, addr, wdata, wstrb, k + 1);
        exp_ack(ack, err, rdata, k + 2);
        step(3);
        drop(i);
        step(1);
    endtask

    initial begin
        int k;
        presetn    = 1'b0;
        m_wr_req   = '0;
        m_rd_req   = '0;
        m_addr     = '0;
        m_wstrb    = '0;
        m_wdata    = '0;
`ifdef RIF_ARB_LOCK_EN
        m_lock     = '0;
`endif
        rif_wvalid = 1'b1;
        rif_rvalid = 1'b1;
        rif_rdata  = '0;
        step(2);
        chk("reset_ack", 64'(m_ack), 64'(0));
        chk("reset_err", 64'(m_err), 64'(0));
        chk("reset_rdata", 64'(m_rdata), 64'(0));
        chk("reset_rif_strobes", 64'({rif_wr_req, rif_rd_req}), 64'(0));
        presetn = 1'b1;
        step(2);

        // Single write, then single read.
        single(0, 1'b1, 12'h010, 32'hA5A5_0001, 4'hF, 2'b01, 1'b0, 32'h0);
        rif_rdata = 32'hDEAD_BEEF;
        single(1, 1'b0, 12'h004, 32'h0, 4'hF, 2'b10, 1'b0, 32'hDEAD_BEEF);

        // Errors: bad write keeps old rdata, next good read clears err, bad read sets it.
        rif_wvalid = 1'b0;
        single(0, 1'b1, 12'h020, 32'h0000_0BAD, 4'h1, 2'b01, 1'b1, 32'hDEAD_BEEF);
        rif_wvalid = 1'b1;
        rif_rdata  = 32'h1234_5678;
        single(0, 1'b0, 12'h008, 32'h0, 4'hF, 2'b01, 1'b0, 32'h1234_5678);
        rif_rvalid = 1'b0;
        rif_rdata  = 32'hCAFE_0000;
        single(1, 1'b0, 12'h00C, 32'h0, 4'hF, 2'b10, 1'b1, 32'hCAFE_0000);
        rif_rvalid = 1'b1;

        // Contention with ptr=0: grants 0,1,0,1, acks three cycles apart.
        k = cyc;
        set_req(0, 1'b1, 12'h100, 32'h11, 4'hF);
        set_req(1, 1'b1, 12'h104, 32'h22, 4'hF);
        exp_rif(1'b1, 12'h100, 32'h11, 4'hF, k + 1);
        exp_ack(2'b01, 1'b0, 32'hCAFE_0000, k + 2);
        exp_rif(1'b1, 12'h104, 32'h22, 4'hF, k + 4);
        exp_ack(2'b10, 1'b0, 32'hCAFE_0000, k + 5);
        exp_rif(1'b1, 12'h108, 32'h33, 4'hF, k + 7);
        exp_ack(2'b01, 1'b0, 32'hCAFE_0000, k + 8);
        exp_rif(1'b1, 12'h10C, 32'h44, 4'hF, k + 10);
        exp_ack(2'b10, 1'b0, 32'hCAFE_0000, k + 11);
        step(3);
        set_req(0, 1'b1, 12'h108, 32'h33, 4'hF);
        step(3);
        set_req(1, 1'b1, 12'h10C, 32'h44, 4'hF);
        step(3);
        drop(0);
        step(3);
        drop(1);
        step(1);

        // Reset in ISSUE: leave ptr at 1 first so a post-reset grant to 0 proves ptr cleared.
        rif_rdata = 32'h55AA_55AA;
        single(0, 1'b0, 12'h00C, 32'h0, 4'hF, 2'b01, 1'b0, 32'h55AA_55AA);
        k = cyc;
        set_req(1, 1'b1, 12'h0F0, 32'h99, 4'b0011);
        exp_rif(1'b1, 12'h0F0, 32'h99, 4'b0011, k + 1);
        step(1);
        presetn = 1'b0;
        drop(1);
        step(1);
        presetn = 1'b1;
        chk("rst_ack", 64'(m_ack), 64'(0));
        chk("rst_err", 64'(m_err), 64'(0));
        chk("rst_rdata", 64'(m_rdata), 64'(0));
        chk("rst_rif_addr", 64'(rif_addr), 64'(0));
        chk("rst_rif_wdata", 64'(rif_wdata), 64'(0));
        chk("rst_rif_wstrb", 64'(rif_wstrb), 64'(0));
        chk("rst_rif_wr_req", 64'(rif_wr_req), 64'(0));
        step(2);
        k = cyc;
        set_req(0, 1'b1, 12'h040, 32'hAB, 4'hF);
        set_req(1, 1'b1, 12'h044, 32'hCD, 4'hF);
        exp_rif(1'b1, 12'h040, 32'hAB, 4'hF, k + 1);
        exp_ack(2'b01, 1'b0, 32'h0, k + 2);
        exp_rif(1'b1, 12'h044, 32'hCD, 4'hF, k + 4);
        exp_ack(2'b10, 1'b0, 32'h0, k + 5);
        step(3);
        drop(0);
        step(3);
        drop(1);
        step(1);

`ifdef RIF_ARB_LOCK_EN
        // Lock: req0 holds three writes while req1's read waits.
        rif_rdata = 32'h77;
        k = cyc;
        set_req(0, 1'b1, 12'h200, 32'h1, 4'hF);
        m_lock[0] = 1'b1;
        set_req(1, 1'b0, 12'h204, 32'h0, 4'hF);
        exp_rif(1'b1, 12'h200, 32'h1, 4'hF, k + 1);
        exp_ack(2'b01, 1'b0, 32'h0, k + 2);
        exp_rif(1'b1, 12'h208, 32'h2, 4'hF, k + 4);
        exp_ack(2'b01, 1'b0, 32'h0, k + 5);
        exp_rif(1'b1, 12'h210, 32'h3, 4'hF, k + 7);
        exp_ack(2'b01, 1'b0, 32'h0, k + 8);
        exp_rif(1'b0, 12'h204, 32'h0, 4'hF, k + 10);
        exp_ack(2'b10, 1'b0, 32'h77, k + 11);
        step(3);
        set_req(0, 1'b1, 12'h208, 32'h2, 4'hF);
        step(3);
        set_req(0, 1'b1, 12'h210, 32'h3, 4'hF);
        m_lock[0] = 1'b0;
        step(3);
        drop(0);
        step(3);
        drop(1);
        step(1);
`endif

        step(4);
        chk("ack_queue_drained", 64'(ack_q.size()), 64'(0));
        chk("rif_queue_drained", 64'(rif_q.size()), 64'(0));
        $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_err);
        $finish;
    end

endmodule
